// File: rtl/rf_wb_queue_if.sv
// Enqueue handshake bundle between late producers and the write-back queue.
// The producer drives the offer; the queue answers with in_ready.
interface rf_wb_queue_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic [DW-1:0] in_pc;
    logic [DW-1:0] in_instr;

    modport master (
        output in_valid,
        output in_addr,
        output in_data,
        output in_pc,
        output in_instr,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_addr,
        input  in_data,
        input  in_pc,
        input  in_instr,
        output in_ready
    );
endinterface

// File: rtl/rf_wb_queue.sv
// Write-back queue feeding the GPR file's single write port.
// Circular FIFO with youngest-match bypass for two D-stage read ports.
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    rf_wb_queue_if.slave           enq,
    input  logic                   drain_en,
    output logic                   RegWrite,
    output logic [AW-1:0]          A3,
    output logic [DW-1:0]          WriteData,
    output logic [DW-1:0]          WPC,
    output logic [DW-1:0]          instr_W,
    input  logic [AW-1:0]          A1,
    input  logic [AW-1:0]          A2,
    output logic                   hit1,
    output logic                   hit2,
    output logic [DW-1:0]          fwd1,
    output logic [DW-1:0]          fwd2,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    addr_q  [DEPTH];
    logic [DW-1:0]    data_q  [DEPTH];
    logic [DW-1:0]    pc_q    [DEPTH];
    logic [DW-1:0]    instr_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;

    logic             nonempty;
    logic             store;
    logic             pop;
    logic [PW-1:0]    idx;

    assign nonempty     = reset && (cnt_q != '0);
    assign enq.in_ready = reset && !flush && (cnt_q != CW'(DEPTH));
    // Zero-destination writes complete the handshake but are dropped.
    assign store        = enq.in_valid && enq.in_ready && (enq.in_addr != '0);
    assign pop          = nonempty && drain_en && !flush;

    assign RegWrite  = nonempty && drain_en;
    assign A3        = nonempty ? addr_q[rd_ptr_q]  : '0;
    assign WriteData = nonempty ? data_q[rd_ptr_q]  : '0;
    assign WPC       = nonempty ? pc_q[rd_ptr_q]    : '0;
    assign instr_W   = nonempty ? instr_q[rd_ptr_q] : '0;
    assign count     = reset ? cnt_q : '0;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= '0;
        end else begin
            if (store) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + 1'b1;
            end
            case ({store, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            addr_q[wr_ptr_q]  <= enq.in_addr;
            data_q[wr_ptr_q]  <= enq.in_data;
            pc_q[wr_ptr_q]    <= enq.in_pc;
            instr_q[wr_ptr_q] <= enq.in_instr;
        end
    end

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (reset && valid_q[idx]) begin
                if (A1 != '0 && addr_q[idx] == A1) begin
                    hit1 = 1'b1;
                    fwd1 = data_q[idx];
                end
                if (A2 != '0 && addr_q[idx] == A2) begin
                    hit2 = 1'b1;
                    fwd2 = data_q[idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_rf_wb_queue.sv
// Bench for rf_wb_queue: queue-model scoreboard checked every cycle,
// a bypass vector table, and directed multi-cycle sequences.
module tb_rf_wb_queue;
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        h1;
        logic [31:0] f1;
        logic        h2;
        logic [31:0] f2;
    } byp_vec_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        drain_en;
    logic        RegWrite;
    logic [4:0]  A3;
    logic [31:0] WriteData;
    logic [31:0] WPC;
    logic [31:0] instr_W;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic        hit1;
    logic        hit2;
    logic [31:0] fwd1;
    logic [31:0] fwd2;
    logic [2:0]  count;

    int tests;
    int fails;
    int dut_writes;
    int pc_ctr;
    ent_t sb[$];
    byp_vec_t vecs[5];

    rf_wb_queue_if #(.AW(5), .DW(32)) enq_if ();

    rf_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .flush     (flush),
        .enq       (enq_if.slave),
        .drain_en  (drain_en),
        .RegWrite  (RegWrite),
        .A3        (A3),
        .WriteData (WriteData),
        .WPC       (WPC),
        .instr_W   (instr_W),
        .A1        (A1),
        .A2        (A2),
        .hit1      (hit1),
        .hit2      (hit2),
        .fwd1      (fwd1),
        .fwd2      (fwd2),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Predict outputs from the model queue, then advance it for the coming edge.
    task automatic mon();
        int n;
        logic eh1, eh2, acc, pp;
        logic [31:0] ef1, ef2;
        ent_t e;
        n = sb.size();
        if (RegWrite) dut_writes++;
        chk("mon_ready", 64'(enq_if.in_ready), 64'(rst_n && !flush && n < 4));
        chk("mon_regwrite", 64'(RegWrite), 64'(rst_n && n != 0 && drain_en));
        chk("mon_count", 64'(count), rst_n ? 64'(n) : 64'd0);
        if (rst_n && n != 0) begin
            chk("mon_a3", 64'(A3), 64'(sb[0].addr));
            chk("mon_wdata", 64'(WriteData), 64'(sb[0].data));
            chk("mon_wpc", 64'(WPC), 64'(sb[0].pc));
            chk("mon_instr", 64'(instr_W), 64'(sb[0].instr));
        end else begin
            chk("mon_a3_idle", 64'(A3), 64'd0);
            chk("mon_wdata_idle", 64'(WriteData), 64'd0);
        end
        if (RegWrite) chk("mon_a3_nonzero", 64'(A3 != 5'd0), 64'd1);
        eh1 = 1'b0; eh2 = 1'b0; ef1 = '0; ef2 = '0;
        for (int i = 0; i < n; i++) begin
            if (rst_n && A1 != 0 && sb[i].addr == A1) begin
                eh1 = 1'b1; ef1 = sb[i].data;
            end
            if (rst_n && A2 != 0 && sb[i].addr == A2) begin
                eh2 = 1'b1; ef2 = sb[i].data;
            end
        end
        chk("mon_hit1", 64'(hit1), 64'(eh1));
        chk("mon_fwd1", 64'(fwd1), 64'(ef1));
        chk("mon_hit2", 64'(hit2), 64'(eh2));
        chk("mon_fwd2", 64'(fwd2), 64'(ef2));
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            acc = enq_if.in_valid && (n < 4);
            pp  = (n != 0) && drain_en;
            if (pp) void'(sb.pop_front());
            if (acc && enq_if.in_addr != 0) begin
                e.addr  = enq_if.in_addr;
                e.data  = enq_if.in_data;
                e.pc    = enq_if.in_pc;
                e.instr = enq_if.in_instr;
                sb.push_back(e);
            end
        end
    endtask

    always @(negedge clk) mon();

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        pc_ctr++;
        enq_if.in_valid = 1'b1;
        enq_if.in_addr  = a;
        enq_if.in_data  = d;
        enq_if.in_pc    = 32'h1000 + 32'(pc_ctr) * 4;
        enq_if.in_instr = $urandom;
        cyc();
        enq_if.in_valid = 1'b0;
    endtask

    initial begin
        int d0;
        tests = 0; fails = 0; dut_writes = 0; pc_ctr = 0;
        vecs[0] = '{5'd7, 5'd3, 1'b1, 32'hC, 1'b1, 32'hB};
        vecs[1] = '{5'd0, 5'd3, 1'b0, 32'h0, 1'b1, 32'hB};
        vecs[2] = '{5'd3, 5'd7, 1'b1, 32'hB, 1'b1, 32'hC};
        vecs[3] = '{5'd9, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[4] = '{5'd7, 5'd7, 1'b1, 32'hC, 1'b1, 32'hC};

        // Reset held with a live offer
        rst_n = 1'b0; flush = 1'b0; drain_en = 1'b0;
        A1 = '0; A2 = '0;
        enq_if.in_valid = 1'b1; enq_if.in_addr = 5'd9;
        enq_if.in_data = 32'h55; enq_if.in_pc = '0; enq_if.in_instr = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready", 64'(enq_if.in_ready), 64'd0);
            chk("rst_regwrite", 64'(RegWrite), 64'd0);
            chk("rst_count", 64'(count), 64'd0);
        end
        cyc();
        rst_n = 1'b1;
        enq_if.in_valid = 1'b0;
        @(negedge clk);
        chk("rel_ready", 64'(enq_if.in_ready), 64'd1);
        cyc();

        // Single write, one-cycle latency
        drain_en = 1'b1;
        push(5'd5, 32'h1234);
        @(negedge clk);
        chk("single_rw", 64'(RegWrite), 64'd1);
        chk("single_a3", 64'(A3), 64'd5);
        chk("single_wd", 64'(WriteData), 64'h1234);
        cyc();
        @(negedge clk);
        chk("single_cnt", 64'(count), 64'd0);
        chk("single_rw0", 64'(RegWrite), 64'd0);
        cyc();

        // Fill to full, refuse fifth, drain in order
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + 32'(i));
        enq_if.in_valid = 1'b1;
        enq_if.in_addr  = 5'd6;
        enq_if.in_data  = 32'h999;
        @(negedge clk);
        chk("full_cnt", 64'(count), 64'd4);
        chk("full_ready", 64'(enq_if.in_ready), 64'd0);
        cyc();
        enq_if.in_valid = 1'b0;
        drain_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("drain_a3", 64'(A3), 64'(i));
            chk("drain_wd", 64'(WriteData), 64'h100 + 64'(i));
            cyc();
        end
        @(negedge clk);
        chk("drain_empty", 64'(count), 64'd0);
        cyc();

        // Youngest-match bypass
        drain_en = 1'b0;
        push(5'd7, 32'hA);
        push(5'd3, 32'hB);
        push(5'd7, 32'hC);
        for (int i = 0; i < 5; i++) begin
            A1 = vecs[i].a1;
            A2 = vecs[i].a2;
            @(negedge clk);
            chk("byp_hit1", 64'(hit1), 64'(vecs[i].h1));
            chk("byp_fwd1", 64'(fwd1), 64'(vecs[i].f1));
            chk("byp_hit2", 64'(hit2), 64'(vecs[i].h2));
            chk("byp_fwd2", 64'(fwd2), 64'(vecs[i].f2));
            cyc();
        end
        drain_en = 1'b1;
        repeat (3) cyc();
        drain_en = 1'b0;
        A1 = '0; A2 = '0;

        // Zero destinations and pointer wrap under continuous drain
        d0 = dut_writes;
        drain_en = 1'b1;
        for (int i = 0; i < 10; i++)
            push((i == 3 || i == 7) ? 5'd0 : 5'(i + 11), $urandom);
        repeat (3) cyc();
        chk("wrap_writes", 64'(dut_writes - d0), 64'd8);
        chk("wrap_cnt", 64'(count), 64'd0);
        drain_en = 1'b0;

        // Flush with a concurrent offer
        push(5'd10, 32'hAA);
        push(5'd11, 32'hBB);
        push(5'd12, 32'hCC);
        flush = 1'b1;
        enq_if.in_valid = 1'b1;
        enq_if.in_addr  = 5'd13;
        enq_if.in_data  = 32'hDD;
        A1 = 5'd13; A2 = 5'd10;
        @(negedge clk);
        chk("flush_ready", 64'(enq_if.in_ready), 64'd0);
        chk("flush_prehit", 64'(hit2), 64'd1);
        cyc();
        flush = 1'b0;
        enq_if.in_valid = 1'b0;
        drain_en = 1'b1;
        @(negedge clk);
        chk("flush_cnt", 64'(count), 64'd0);
        chk("flush_hit1", 64'(hit1), 64'd0);
        chk("flush_hit2", 64'(hit2), 64'd0);
        chk("flush_rw", 64'(RegWrite), 64'd0);
        cyc();
        drain_en = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
